// File: rtl/keypad_pkg.sv
// Shared key map for the 4x3 keypad scanner: key codes, key indices and helpers.
package keypad_pkg;

    localparam logic [3:0] KEY_0    = 4'd0;
    localparam logic [3:0] KEY_1    = 4'd1;
    localparam logic [3:0] KEY_2    = 4'd2;
    localparam logic [3:0] KEY_3    = 4'd3;
    localparam logic [3:0] KEY_4    = 4'd4;
    localparam logic [3:0] KEY_5    = 4'd5;
    localparam logic [3:0] KEY_6    = 4'd6;
    localparam logic [3:0] KEY_7    = 4'd7;
    localparam logic [3:0] KEY_8    = 4'd8;
    localparam logic [3:0] KEY_9    = 4'd9;
    localparam logic [3:0] KEY_STAR = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    localparam int IDX_0    = 10;
    localparam int IDX_8    = 7;
    localparam int IDX_STAR = 9;

    // Key index is row*3 + col; rows run 1-2-3 / 4-5-6 / 7-8-9 / *-0-#.
    function automatic logic [3:0] idx_to_code(input logic [3:0] idx);
        case (idx)
            4'd0:    return KEY_1;
            4'd1:    return KEY_2;
            4'd2:    return KEY_3;
            4'd3:    return KEY_4;
            4'd4:    return KEY_5;
            4'd5:    return KEY_6;
            4'd6:    return KEY_7;
            4'd7:    return KEY_8;
            4'd8:    return KEY_9;
            4'd9:    return KEY_STAR;
            4'd10:   return KEY_0;
            4'd11:   return KEY_HASH;
            default: return KEY_0;
        endcase
    endfunction

    function automatic logic [2:0] col_drive(input logic [1:0] col);
        return ~(3'b001 << col);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Single-key debouncer: stable state plus agreement counter, updated only on sample_en.
module keypad_debounce #(
    parameter int DEB_SCANS = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_en,
    input  logic pressed,
    output logic held,
    output logic rise
);

    localparam logic [2:0] DEB_LAST = 3'(DEB_SCANS - 1);

    logic [2:0] cnt;

    // Asserted during the sample cycle whose edge flips the stable state 0->1.
    assign rise = sample_en && pressed && !held && (cnt == DEB_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held <= 1'b0;
            cnt  <= 3'd0;
        end else if (sample_en) begin
            if (pressed == held) begin
                cnt <= 3'd0;
            end else if (cnt == DEB_LAST) begin
                held <= pressed;
                cnt  <= 3'd0;
            end else begin
                cnt <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/keypad_scan.sv
// 4x3 keypad column scanner, row synchronizer, per-key debounce and press strobe.
// Optional autorepeat of the last strobed key when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int DWELL      = 4,
    parameter int DEB_SCANS  = 3,
    parameter int REPEAT_DLY = 40,
    parameter int REPEAT_PER = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] key_held,
    output logic        key_press,
    output logic [3:0]  key_code,
    output logic        key0,
    output logic        key8,
    output logic        key_star
);

    localparam int              DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    logic [3:0]      row_sync_p0;
    logic [3:0]      row_sync_p1;
    logic [DW_W-1:0] dwell;
    logic [1:0]      col;
    logic [1:0]      col_nxt;
    logic            sample;
    logic [11:0]     rise;
    logic            hit;
    logic [3:0]      hit_idx;

    assign sample  = (dwell == DWELL_LAST);
    assign col_nxt = (col == 2'd2) ? 2'd0 : col + 2'd1;

    // Stage p0/p1: two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_sync_p0 <= 4'b1111;
            row_sync_p1 <= 4'b1111;
            dwell       <= '0;
            col         <= 2'd0;
            key_col     <= 3'b110;
        end else begin
            row_sync_p0 <= key_row;
            row_sync_p1 <= row_sync_p0;
            if (sample) begin
                dwell   <= '0;
                col     <= col_nxt;
                key_col <= col_drive(col_nxt);
            end else begin
                dwell <= dwell + 1'b1;
            end
        end
    end

    for (genvar k = 0; k < 12; k++) begin : g_key
        keypad_debounce #(
            .DEB_SCANS(DEB_SCANS)
        ) u_deb (
            .clk      (clk),
            .rst      (rst),
            .sample_en(sample && (col == 2'(k % 3))),
            .pressed  (~row_sync_p1[k / 3]),
            .held     (key_held[k]),
            .rise     (rise[k])
        );
    end

    // Only the sampled column can rise; the lowest index there is the lowest row.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (rise[i]) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam logic [15:0] SCAN_LAST = 16'(3 * DWELL - 1);
    localparam logic [15:0] DLY_SCANS = 16'(REPEAT_DLY);
    localparam logic [15:0] PER_SCANS = 16'(REPEAT_PER);

    logic        rpt_active;
    logic        rpt_first;
    logic [3:0]  rpt_idx;
    logic [15:0] rpt_cyc;
    logic [15:0] rpt_scans;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_press  <= 1'b0;
            key_code   <= 4'd0;
            rpt_active <= 1'b0;
            rpt_first  <= 1'b0;
            rpt_idx    <= 4'd0;
            rpt_cyc    <= 16'd0;
            rpt_scans  <= 16'd0;
        end else if (hit) begin
            key_press  <= 1'b1;
            key_code   <= idx_to_code(hit_idx);
            rpt_active <= 1'b1;
            rpt_first  <= 1'b1;
            rpt_idx    <= hit_idx;
            rpt_cyc    <= 16'd0;
            rpt_scans  <= 16'd0;
        end else if (rpt_active && key_held[rpt_idx]) begin
            key_press <= 1'b0;
            if (rpt_cyc == SCAN_LAST) begin
                rpt_cyc <= 16'd0;
                if (rpt_scans + 16'd1 == (rpt_first ? DLY_SCANS : PER_SCANS)) begin
                    key_press <= 1'b1;
                    rpt_scans <= 16'd0;
                    rpt_first <= 1'b0;
                end else begin
                    rpt_scans <= rpt_scans + 16'd1;
                end
            end else begin
                rpt_cyc <= rpt_cyc + 16'd1;
            end
        end else begin
            key_press  <= 1'b0;
            rpt_active <= 1'b0;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{32'(REPEAT_DLY), 32'(REPEAT_PER)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_press <= 1'b0;
            key_code  <= 4'd0;
        end else begin
            key_press <= hit;
            if (hit) begin
                key_code <= idx_to_code(hit_idx);
            end
        end
    end
`endif

    assign key0     = key_held[IDX_0];
    assign key8     = key_held[IDX_8];
    assign key_star = key_held[IDX_STAR];

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: keypad matrix model driving the rows, cycle-level reference model, directed scenarios.
module tb_keypad_scan;

    localparam int DWELL = 4;
    localparam int DEB   = 3;
    localparam int RDLY  = 40;
    localparam int RPER  = 10;
    localparam int SCAN  = 3 * DWELL;

    logic        clk;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_held;
    logic        key_press;
    logic [3:0]  key_code;
    logic        key0;
    logic        key8;
    logic        key_star;

    logic [11:0] pressed;

    int n_checks = 0;
    int n_errors = 0;

    keypad_scan #(
        .DWELL     (DWELL),
        .DEB_SCANS (DEB),
        .REPEAT_DLY(RDLY),
        .REPEAT_PER(RPER)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_row  (key_row),
        .key_col  (key_col),
        .key_held (key_held),
        .key_press(key_press),
        .key_code (key_code),
        .key0     (key0),
        .key8     (key8),
        .key_star (key_star)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its row to its column when that column is driven low.
    always_comb begin
        key_row = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3 + c] && !key_col[c]) key_row[r] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int bound);
        n_checks++;
        if (act > bound) begin
            n_errors++;
            $display("FAIL %s: got %0d required at most %0d", name, act, bound);
        end
    endtask

    // Reference model state, advanced once per clock from the specification's rules.
    int          code_tab [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int          t;
    logic [3:0]  h1, h2;
    logic [11:0] m_held;
    int          run [12];
    logic        m_press;
    logic [3:0]  m_code;
    int          since;
    int          rk;
    bit          ra, rfirst;

    int          cyc = 0;
    int          n_press = 0;
    int          last_code = -1;
    int          last_press_cyc = 0;
    int          press_t[$];
    logic [11:0] seen_held = '0;

    initial begin
        forever begin
            logic [2:0]  exp_col;
            logic [22:0] exp_v, act_v;
            logic [11:0] pre_held;
            logic        np;
            logic [3:0]  nc;
            @(negedge clk);
            cyc++;
            if (rst) begin
                t = 0; h1 = 4'hF; h2 = 4'hF; m_held = '0; m_press = 1'b0; m_code = 4'd0;
                for (int k = 0; k < 12; k++) run[k] = 0;
                ra = 1'b0; rfirst = 1'b0; since = 0; rk = 0;
            end
            exp_col = ~(3'b001 << ((t / DWELL) % 3));
            exp_v = {exp_col, m_held, m_press, m_code, m_held[10], m_held[7], m_held[9]};
            act_v = {key_col, key_held, key_press, key_code, key0, key8, key_star};
            check("cycle_outputs", 32'(act_v), 32'(exp_v));

            if (key_press === 1'b1) begin
                n_press++;
                last_code = int'(key_code);
                last_press_cyc = cyc;
                press_t.push_back(cyc);
            end
            seen_held = seen_held | key_held;

            if (!rst) begin
                pre_held = m_held;
                np = 1'b0;
                nc = m_code;
                if (t % DWELL == DWELL - 1) begin
                    for (int r = 0; r < 4; r++) begin
                        int  k;
                        logic p;
                        k = r * 3 + (t / DWELL) % 3;
                        p = (h2[r] == 1'b0);
                        if (p == m_held[k]) run[k] = 0;
                        else begin
                            run[k]++;
                            if (run[k] == DEB) begin
                                m_held[k] = p;
                                run[k] = 0;
                                if (p && !np) begin
                                    np = 1'b1;
                                    nc = 4'(code_tab[k]);
                                    rk = k;
                                end
                            end
                        end
                    end
                end
`ifdef KEYPAD_AUTOREPEAT_EN
                if (np) begin
                    ra = 1'b1; rfirst = 1'b1; since = 0;
                end else if (ra && pre_held[rk]) begin
                    since++;
                    if (since == (rfirst ? RDLY * SCAN : RPER * SCAN)) begin
                        np = 1'b1; since = 0; rfirst = 1'b0;
                    end
                end else begin
                    ra = 1'b0;
                end
`endif
                m_press = np;
                m_code = nc;
                h2 = h1;
                h1 = key_row;
                t++;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2:0] col_lit [3];
        int base, apply_c;
        col_lit = '{3'b110, 3'b101, 3'b011};
        pressed = '0;
        rst = 1'b0;
        #1 rst = 1'b1;
        step(3);
        check("rst_key_col", 32'(key_col), 32'h6);
        check("rst_key_held", 32'(key_held), 32'h0);
        check("rst_key_press", 32'(key_press), 32'h0);
        check("rst_key_code", 32'(key_code), 32'h0);
        rst = 1'b0;

        // Idle scan: 4 cycles per column, rows all high.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("idle_col_seq", 32'(key_col), 32'(col_lit[(i / 4) % 3]));
        end
        step(100);
        check("idle_held", 32'(key_held), 32'h0);
        check("idle_no_press", 32'(n_press), 32'd0);
        check("idle_seen_held", 32'(seen_held), 32'h0);

        // Key 8: row 2, column 1.
        base = n_press;
        apply_c = cyc;
        pressed[7] = 1'b1;
        step(60);
        check("key8_level", 32'(key8), 32'd1);
        check("key8_one_strobe", 32'(n_press - base), 32'd1);
        check("key8_code", 32'(last_code), 32'd8);
        check_le("key8_press_latency", last_press_cyc - apply_c, 37);
        pressed[7] = 1'b0;
        step(37);
        check("key8_release_37", 32'(key8), 32'd0);
        step(23);
        check("key8_release_no_strobe", 32'(n_press - base), 32'd1);

        // Star bounce: low for exactly two of its samples.
        base = n_press;
        seen_held = '0;
        pressed[9] = 1'b1;
        step(24);
        pressed[9] = 1'b0;
        step(60);
        check("star_bounce_never_held", 32'(seen_held[9]), 32'd0);
        check("star_bounce_level", 32'(key_star), 32'd0);
        check("star_bounce_no_strobe", 32'(n_press - base), 32'd0);

        // Keys 1 and 4 together in column 0: lowest row wins the strobe.
        base = n_press;
        pressed[0] = 1'b1;
        pressed[3] = 1'b1;
        step(60);
        check("dual_held_1", 32'(key_held[0]), 32'd1);
        check("dual_held_4", 32'(key_held[3]), 32'd1);
        check("dual_one_strobe", 32'(n_press - base), 32'd1);
        check("dual_code", 32'(last_code), 32'd1);
        pressed[0] = 1'b0;
        pressed[3] = 1'b0;
        step(60);
        check("dual_released", 32'(key_held), 32'h0);

        // Key 0 with reset mid-hold.
        base = n_press;
        pressed[10] = 1'b1;
        step(60);
        check("key0_level", 32'(key0), 32'd1);
        check("key0_one_strobe", 32'(n_press - base), 32'd1);
        check("key0_code", 32'(last_code), 32'd0);
        rst = 1'b1;
        step(3);
        check("midrst_key_col", 32'(key_col), 32'h6);
        check("midrst_key_held", 32'(key_held), 32'h0);
        check("midrst_key_press", 32'(key_press), 32'h0);
        check("midrst_key_code", 32'(key_code), 32'h0);
        rst = 1'b0;
        base = n_press;
        step(60);
        check("key0_rearm_level", 32'(key0), 32'd1);
        check("key0_rearm_strobe", 32'(n_press - base), 32'd1);
        check("key0_rearm_code", 32'(last_code), 32'd0);
        pressed[10] = 1'b0;
        step(60);

        // Hash held for 700 cycles.
        base = n_press;
        press_t.delete();
        pressed[11] = 1'b1;
        step(700);
        pressed[11] = 1'b0;
        step(60);
        check("hash_code", 32'(last_code), 32'd11);
`ifdef KEYPAD_AUTOREPEAT_EN
        check("hash_strobe_count", 32'(n_press - base), 32'd3);
        if (press_t.size() >= 3) begin
            check("hash_first_repeat_gap", 32'(press_t[1] - press_t[0]), 32'd480);
            check("hash_next_repeat_gap", 32'(press_t[2] - press_t[1]), 32'd120);
        end
`else
        check("hash_strobe_count", 32'(n_press - base), 32'd1);
`endif
        check("final_held", 32'(key_held), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix keypad scanner and debouncer that produces the `key0`, `key8` and `key_star` levels consumed by the game and event controllers. It also produces an encoded press event for any of the 12 keys. It is the input end of the key interface: it drives the column lines of a 4x3 phone keypad, samples the rows through a synchronizer, debounces every key, and emits stable levels plus one-cycle press strobes. It runs on the same 1 kHz system clock as the game logic.

## Interface
Parameters:
- `DWELL`, default 4: cycles each column is driven; legal range is 4 or more.
- `DEB_SCANS`, default 3: consecutive agreeing samples needed to change a key's stable state; legal range is 1 to 7.
- `REPEAT_DLY`, default 40: full scans a key must be held before autorepeat starts.
- `REPEAT_PER`, default 10: full scans between autorepeat strobes.

Ports:
- `clk`, input, 1 bit: system clock (1 kHz).
- `rst`, input, 1 bit: reset, asynchronous, active-high.
- `key_row`, input, 4 bits: raw row lines, active-low, asynchronous to `clk`.
- `key_col`, output, 3 bits: column drive, one-hot active-low.
- `key_held`, output, 12 bits: debounced level per key index.
- `key_press`, output, 1 bit: one-cycle strobe for a new press.
- `key_code`, output, 4 bits: code of the last strobed key; holds its value between strobes.
- `key0`, output, 1 bit: debounced level of key 0.
- `key8`, output, 1 bit: debounced level of key 8.
- `key_star`, output, 1 bit: debounced level of key `*`.

## Operation
Key map and codes:
- Key index is row*3 + col.
- Row 0 is keys 1 2 3; row 1 is 4 5 6; row 2 is 7 8 9; row 3 is * 0 #.
- Codes: digits map to their value, `*` is 10, `#` is 11.

Scan:
- The column counter steps 0→1→2→0. Each column is held low for `DWELL` cycles; the other columns are driven high.
- `key_row` passes through a 2-flop synchronizer.
- The synchronized rows are sampled on the last dwell cycle of the column (dwell index `DWELL`-1). A row read as 0 means the key is pressed.

Debounce, per key, applied only at its column's sample:
- If the sample equals the stable state, the counter clears.
- Otherwise the counter increments. When it reaches `DEB_SCANS`, the stable state flips and the counter clears.
- `key_held` is the stable state. `key0`, `key8` and `key_star` are `key_held` bits 10, 7 and 9.

Press events:
- A 0→1 flip of a stable state at a sample asserts `key_press` on the next cycle, with `key_code` updated on that same cycle.
- If several keys in the same column flip to 1 at one sample, the lowest row wins. The other keys update `key_held` but produce no strobe.
- Keys in different columns are evaluated at different samples, so each produces its own strobe.
- Releases produce no strobe.

Reset:
- Outputs: `key_col` = 3'b110, `key_held` = 0, `key_press` = 0, `key_code` = 0.
- Internal state: synchronizer flops = 4'b1111, all counters = 0, column = 0, dwell = 0.
- Asserting reset during a hold returns everything to the reset values. After release, a still-held key re-debounces and strobes again.

## Timing
- One full scan takes 3*`DWELL` cycles, which is 12 ms at the defaults.
- Press latency: the `DEB_SCANS`-th consecutive low sample occurs, and `key_press` follows 1 cycle after it. Worst case from a stable row low to the strobe is `DEB_SCANS`*3*`DWELL` + 1 cycles, 37 at the defaults.
- Release latency has the same bound, visible on `key_held`.
- Bounce shorter than `DEB_SCANS` consecutive samples never changes `key_held`.
- `key_col` changes only on dwell wrap. The outputs have no combinational path from `key_row`.

## Configuration
`KEYPAD_AUTOREPEAT_EN`:
- Defined: while the key that produced the last strobe (`key_code`) remains held, a counter counts full scans. The first repeat strobe comes `REPEAT_DLY` scans after the original strobe, then one every `REPEAT_PER` scans. Repeat strobes keep the same `key_code`. A new press or the release of that key stops repeating and clears the counter.
- Undefined: exactly one strobe per press, and the repeat logic is absent.

## Structure
- Package `keypad_pkg`: key code constants `KEY_0`…`KEY_9`, `KEY_STAR`, `KEY_HASH`; index constants `IDX_0` = 10, `IDX_8` = 7, `IDX_STAR` = 9; and an index-to-code function.
- Sub-module `keypad_debounce`: one key's stable state, counter and rise flag. It is instantiated 12 times with a sample-enable input.

## Test plan
- Reset, then idle with rows high for 100 cycles → `key_col` cycles 110→101→011 every 4 cycles, `key_held` = 0, and no `key_press`.
- Hold key 8 (row 2 low while col 1 is low) for 60 cycles → `key8` = 1 and one `key_press` with `key_code` = 8, both within 37 cycles. Release → `key8` = 0 within 37 cycles, with no strobe.
- Bounce key `*` low for 2 of its samples, then high → `key_star` stays 0 and no strobe occurs.
- Press keys 1 and 4 together (column 0, rows 0 and 1) → `key_held[0]` = `key_held[3]` = 1 and exactly one strobe with `key_code` = 1.
- Hold key 0, assert `rst` mid-hold for 3 cycles, keep holding → all outputs return to reset values, then `key0` rises again with one new strobe carrying code 0.
- With `KEYPAD_AUTOREPEAT_EN` defined, hold `#` for 700 cycles → strobes with code 11 at the press, at +480 cycles, then every 120 cycles. Undefined → a single strobe.
